// File: rtl/fa_check_pkg.sv
// Shared types and constants for the full-adder response checker.
// Holds the sweep FSM encoding and the default vector/result widths.
package fa_check_pkg;

  localparam int DEF_VEC_W = 3;
  localparam int DEF_RES_W = 2;

  function automatic int sweep_len(input int vec_w);
    return 1 << vec_w;
  endfunction

  localparam int DEF_SWEEP_LEN = sweep_len(DEF_VEC_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fa_check_stage.sv
// Registered compare stage: captures one accepted vector with both results
// and flags a mismatch on the following cycle.
module fa_check_stage
  import fa_check_pkg::*;
#(
  parameter int VEC_W = DEF_VEC_W,
  parameter int RES_W = DEF_RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VEC_W-1:0] vec,
  input  logic [RES_W-1:0] dut_res,
  input  logic [RES_W-1:0] ref_res,
  output logic             mismatch,
  output logic [VEC_W-1:0] stage_vec
);

  logic             stage_valid;
  logic [RES_W-1:0] stage_dut;
  logic [RES_W-1:0] stage_ref;

  // stage_valid follows load every cycle, so a gap empties the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_vec   <= '0;
      stage_dut   <= '0;
      stage_ref   <= '0;
    end else begin
      stage_valid <= load;
      if (load) begin
        stage_vec <= vec;
        stage_dut <= dut_res;
        stage_ref <= ref_res;
      end
    end
  end

  assign mismatch = stage_valid && (stage_dut != stage_ref);

endmodule

// File: rtl/fa_resp_checker.sv
// Full-adder response checker: sweep FSM, sequence check, saturating error
// counter and first/last failing-vector capture behind a one-stage compare.
module fa_resp_checker
  import fa_check_pkg::*;
#(
  parameter int VEC_W = DEF_VEC_W,
  parameter int RES_W = DEF_RES_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] vec,
  input  logic [RES_W-1:0] dut_res,
  input  logic [RES_W-1:0] ref_res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [VEC_W:0]   vec_count,
  output logic             first_err_valid,
  output logic [VEC_W-1:0] first_err_vec,
  output logic [VEC_W-1:0] last_err_vec,
  output logic             seq_err,
  output logic [1:0]       state_dbg
);

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered state, never on in_valid.
  localparam logic [VEC_W:0] LAST_IDX = {1'b0, {VEC_W{1'b1}}};

  state_t           state, state_next;
  logic             accept;
  logic             last_accept;
  logic             clear;
  logic             mismatch;
  logic [VEC_W-1:0] stage_vec;

  assign in_ready    = (state == RUN);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (vec_count == LAST_IDX);
  assign clear       = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_accept) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  fa_check_stage #(
    .VEC_W (VEC_W),
    .RES_W (RES_W)
  ) u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .vec       (vec),
    .dut_res   (dut_res),
    .ref_res   (ref_res),
    .mismatch  (mismatch),
    .stage_vec (stage_vec)
  );

  // clear and mismatch never coincide: the stage is empty in IDLE and DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count       <= '0;
      vec_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      last_err_vec    <= '0;
      seq_err         <= 1'b0;
    end else if (clear) begin
      err_count       <= '0;
      vec_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      last_err_vec    <= '0;
      seq_err         <= 1'b0;
    end else begin
      if (accept) begin
        vec_count <= vec_count + 1'b1;
        if (vec != vec_count[VEC_W-1:0]) seq_err <= 1'b1;
      end
      if (mismatch) begin
        if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
        last_err_vec <= stage_vec;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= stage_vec;
        end
      end
    end
  end

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0) && !seq_err;
  assign state_dbg = state;

endmodule

// File: tb/tb_fa_resp_checker.sv
// Bench for fa_resp_checker: table-driven sweeps, random sweeps against a
// sweep-level model, a cycle monitor for counters, and reset/saturation cases.
module tb_fa_resp_checker;
  import fa_check_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] vec = '0;
  logic [1:0] dut_res = '0;
  logic [1:0] ref_res = '0;

  logic       in_ready, busy, done, pass, first_err_valid, seq_err;
  logic [7:0] err_count;
  logic [3:0] vec_count;
  logic [2:0] first_err_vec, last_err_vec;
  logic [1:0] state_dbg;

  logic       s_in_ready, s_busy, s_done, s_pass, s_first_err_valid, s_seq_err;
  logic [1:0] s_err_count;
  logic [3:0] s_vec_count;
  logic [2:0] s_first_err_vec, s_last_err_vec;
  logic [1:0] s_state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [23:0] vecs;
    logic [15:0] dres;
    logic [15:0] rres;
    int          gap;
    int          exp_err;
    int          exp_err2;
    int          exp_fv;
    int          exp_first;
    int          exp_last;
    int          exp_seq;
    int          exp_pass;
  } row_t;

  row_t       rows[6];
  logic [1:0] exp_q[$];

  fa_resp_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .vec(vec), .dut_res(dut_res), .ref_res(ref_res),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .vec_count(vec_count), .first_err_valid(first_err_valid),
    .first_err_vec(first_err_vec), .last_err_vec(last_err_vec),
    .seq_err(seq_err), .state_dbg(state_dbg)
  );

  fa_resp_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(s_in_ready), .vec(vec), .dut_res(dut_res), .ref_res(ref_res),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
    .vec_count(s_vec_count), .first_err_valid(s_first_err_valid),
    .first_err_vec(s_first_err_vec), .last_err_vec(s_last_err_vec),
    .seq_err(s_seq_err), .state_dbg(s_state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fa(input logic [2:0] v);
    return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
  endfunction

  function automatic logic [15:0] fa_all(input logic [23:0] vecs);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*2 +: 2] = fa(vecs[i*3 +: 3]);
    return r;
  endfunction

  // Sweep-level reference: derives final status from the list of vectors.
  function automatic row_t model_row(input string nm, input logic [23:0] vecs,
                                     input logic [15:0] dres, input logic [15:0] rres,
                                     input int gap);
    row_t r;
    int   errs;
    r.name = nm; r.vecs = vecs; r.dres = dres; r.rres = rres; r.gap = gap;
    r.exp_first = 0; r.exp_last = 0; r.exp_seq = 0;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i*3 +: 3] != 3'(i)) r.exp_seq = 1;
      if (dres[i*2 +: 2] != rres[i*2 +: 2]) begin
        if (errs == 0) r.exp_first = int'(vecs[i*3 +: 3]);
        r.exp_last = int'(vecs[i*3 +: 3]);
        errs++;
      end
    end
    r.exp_err  = (errs > 255) ? 255 : errs;
    r.exp_err2 = (errs > 3) ? 3 : errs;
    r.exp_fv   = (errs > 0) ? 1 : 0;
    r.exp_pass = (errs == 0 && r.exp_seq == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_vec_count"}, vec_count, 0);
    check({tag, "_first_valid"}, first_err_valid, 0);
    check({tag, "_first_vec"}, first_err_vec, 0);
    check({tag, "_last_vec"}, last_err_vec, 0);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_state"}, state_dbg, 32'(IDLE));
    check({tag, "_sat_err"}, s_err_count, 0);
  endtask

  // ---------------- driver ----------------
  task automatic run_sweep(input row_t r, input int abort_after);
    int acc;
    int guard;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({r.name, "_clr_err"}, err_count, 0);
    check({r.name, "_clr_sat_err"}, s_err_count, 0);
    check({r.name, "_clr_seq"}, seq_err, 0);
    check({r.name, "_clr_fv"}, first_err_valid, 0);
    check({r.name, "_clr_done"}, done, 0);
    check({r.name, "_run_ready"}, in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_after) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero({r.name, "_abort"});
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      acc = 0;
      guard = 0;
      while (acc == 0) begin
        if ($urandom_range(99) < r.gap) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          vec     = r.vecs[i*3 +: 3];
          dut_res = r.dres[i*2 +: 2];
          ref_res = r.rres[i*2 +: 2];
          acc     = int'(in_ready);
        end
        @(negedge clk);
        guard++;
        if (guard > 200) begin
          check({r.name, "_accept_timeout"}, 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    check({r.name, "_drain_ready"}, in_ready, 0);
    check({r.name, "_drain_busy"}, busy, 1);
    check({r.name, "_drain_done"}, done, 0);
    @(negedge clk);
    check({r.name, "_done"}, done, 1);
    check({r.name, "_busy_off"}, busy, 0);
    check({r.name, "_vec_count"}, vec_count, 8);
    check({r.name, "_err_count"}, err_count, 32'(r.exp_err));
    check({r.name, "_sat_err_count"}, s_err_count, 32'(r.exp_err2));
    check({r.name, "_first_valid"}, first_err_valid, 32'(r.exp_fv));
    check({r.name, "_first_vec"}, first_err_vec, 32'(r.exp_first));
    check({r.name, "_last_vec"}, last_err_vec, 32'(r.exp_last));
    check({r.name, "_seq_err"}, seq_err, 32'(r.exp_seq));
    check({r.name, "_pass"}, pass, 32'(r.exp_pass));
    check({r.name, "_sat_pass"}, s_pass, 32'(r.exp_pass));
  endtask

  // ---------------- cycle monitor / scoreboard ----------------
  // exp_q delays each transfer decision by two edges: one for the accept,
  // one for the compare stage to update err_count.
  initial begin
    int         m_err, m_err2, m_vcnt;
    logic [1:0] d, last_dec;
    logic       last_start;
    m_err = 0; m_err2 = 0; m_vcnt = 0; last_dec = '0; last_start = 1'b0;
    exp_q = {2'b00, 2'b00};
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        m_err = 0; m_err2 = 0; m_vcnt = 0; last_dec = '0; last_start = 1'b0;
        exp_q = {2'b00, 2'b00};
      end else begin
        if (last_start) begin
          m_err = 0; m_err2 = 0; m_vcnt = 0;
        end
        if (last_dec[1]) m_vcnt++;
        d = exp_q.pop_front();
        if (d == 2'b11) begin
          if (m_err < 255) m_err++;
          if (m_err2 < 3) m_err2++;
        end
        last_dec   = {in_valid && in_ready, dut_res != ref_res};
        last_start = start;
        exp_q.push_back(last_dec);
      end
      check("mon_err_count", err_count, 32'(m_err));
      check("mon_sat_err_count", s_err_count, 32'(m_err2));
      check("mon_vec_count", vec_count, 32'(m_vcnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [23:0] idv, v;
    logic [15:0] idr, t, dr, rr;
    row_t        rr_row;

    idv = '0;
    for (int i = 0; i < DEF_SWEEP_LEN; i++) idv[i*3 +: 3] = 3'(i);
    idr = fa_all(idv);

    rows[0] = '{"clean", idv, idr, idr, 0, 0, 0, 0, 0, 0, 0, 1};
    t = idr; t[10 +: 2] = ~t[10 +: 2];
    rows[1] = '{"err_at5", idv, idr, t, 0, 1, 1, 1, 5, 5, 0, 0};
    t = idr; t[4 +: 2] = ~t[4 +: 2]; t[12 +: 2] = t[12 +: 2] ^ 2'b01;
    rows[2] = '{"err_2_6_gaps", idv, idr, t, 35, 2, 2, 1, 2, 6, 0, 0};
    v = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd3, 3'd1, 3'd0};
    rows[3] = '{"seq_skip", v, fa_all(v), fa_all(v), 0, 0, 0, 0, 0, 0, 1, 0};
    rows[4] = '{"all_err_sat", idv, idr, ~idr, 10, 8, 3, 1, 0, 7, 0, 0};
    rows[5] = '{"clean_gaps", idv, idr, idr, 25, 0, 0, 0, 0, 0, 0, 1};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    for (int k = 0; k < 6; k++) run_sweep(rows[k], -1);

    for (int k = 0; k < 4; k++) begin
      v = '0; dr = '0; rr = '0;
      for (int i = 0; i < 8; i++) begin
        v[i*3 +: 3]  = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'(i);
        dr[i*2 +: 2] = 2'($urandom_range(3));
        rr[i*2 +: 2] = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : dr[i*2 +: 2];
      end
      rr_row = model_row($sformatf("rand%0d", k), v, dr, rr, int'($urandom_range(40)));
      run_sweep(rr_row, -1);
    end

    run_sweep(rows[1], 4);
    @(negedge clk);
    check_all_zero("after_abort");
    run_sweep(rows[0], -1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_resp_checker.md
# fa_resp_checker

Hardware response checker for the full-adder verification flow. It receives one {a, b, c_in} vector per handshake, together with the DUT result {c_out, sum} and the golden-model result. It compares them in a registered stage, counts mismatches and captures the first and last failing vectors. It asserts done and pass after a complete exhaustive sweep of 2^VEC_W vectors. The block sits downstream of the stimulus/DUT/golden-model pair and replaces clocked $display checking with synthesizable, observable status.

## Interface
Parameters:
- VEC_W, 3, input vector width ({a, b, c_in}); sweep length is 2^VEC_W
- RES_W, 2, result width ({c_out, sum})
- CNT_W, 8, width of the saturating error counter

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a sweep
- in_valid  in  1  vec, dut_res and ref_res are valid
- in_ready  out  1  checker accepts a vector this cycle
- vec  in  VEC_W  applied input vector
- dut_res  in  RES_W  DUT output
- ref_res  in  RES_W  golden-model output
- busy  out  1  sweep in progress (RUN or DRAIN)
- done  out  1  sweep complete; held until next start
- pass  out  1  valid when done=1: no errors and no sequence errors
- err_count  out  CNT_W  mismatches, saturating at 2^CNT_W-1
- vec_count  out  VEC_W+1  vectors accepted this sweep
- first_err_valid  out  1  at least one mismatch captured
- first_err_vec  out  VEC_W  vector of first mismatch
- last_err_vec  out  VEC_W  vector of most recent mismatch
- seq_err  out  1  sticky; an accepted vec did not equal the expected index

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE/DONE with start=1 → RUN.
  - Clears err_count, vec_count, first_err_valid, first_err_vec, last_err_vec, seq_err and done.
  - start is ignored in RUN and DRAIN.
- RUN: in_ready=1. Accept occurs when in_valid && in_ready.
  - The accept loads the compare-stage register {vec, dut_res, ref_res} and sets the stage-valid bit.
  - The accept increments vec_count.
- Expected vector equals vec_count[VEC_W-1:0].
  - On accept with vec ≠ expected: set seq_err.
  - A sequence error does not increment err_count.
- Compare stage: stage-valid && (dut_res ≠ ref_res) is a mismatch.
  - A mismatch increments err_count, saturating.
  - A mismatch sets last_err_vec.
  - On the first mismatch of the sweep, a mismatch also sets first_err_vec and first_err_valid.
- Accept of vector number 2^VEC_W (vec_count reaches 2^VEC_W) → DRAIN. in_ready=0 in DRAIN.
- DRAIN → DONE on the next edge, after the last compare has been applied. DONE sets done=1.
- pass = done && (err_count == 0) && !seq_err.

## Timing
- Reset (async, any state): FSM=IDLE; every output is 0. This includes in_ready, busy, done, pass and all counters and capture registers. Stage-valid is cleared.
- in_ready is a registered-state decode: 1 exactly in RUN.
- Latency: vector accepted at edge N → err_count and error captures updated at edge N+1.
- Last accept at edge N → DRAIN at N, DONE and done=1 at N+1.
- Back-to-back accepts are supported, one per cycle. in_valid gaps do not stall or alter any count.
- Simultaneous start in DONE: the clear has priority; no stale status survives into RUN.
- Reset mid-sweep aborts immediately. The next sweep requires a new start.
- err_count saturation: it holds its maximum value and does not wrap. vec_count never exceeds 2^VEC_W.

## Structure
- Shared package fa_check_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default widths VEC_W=3, RES_W=2;
  - the sweep-length constant.
- One natural sub-module: fa_check_stage. It is the registered compare stage and outputs mismatch and stage_vec.
- The top module holds the FSM, counters and capture registers.

## Test plan
- Reset, start, then 8 matching vectors 0..7 with in_valid held high → done at edge after the 8th accept, err_count=0, pass=1, vec_count=8.
- ref_res differs only at vec=3'b101 → err_count=1, first_err_vec=5, last_err_vec=5, pass=0.
- Mismatches at vec=2 and vec=6 with random in_valid gaps → err_count=2, first_err_vec=2, last_err_vec=6; no counts during gaps.
- Send vec sequence 0,1,3,… → seq_err=1, err_count=0, pass=0 at done.
- rst_n low after 4 accepts → outputs all 0, state IDLE; a new start and a clean sweep → pass=1.
- CNT_W=2, all 8 vectors mismatch → err_count saturates at 3; a second start clears it to 0.
